// File: rtl/spi_cmd_queue_if.sv
// Command/response handshake bundle between user logic (master) and spi_cmd_queue (slave).
interface spi_cmd_queue_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_mode;
    logic [15:0] cmd_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [15:0] rsp_data;
    logic        rsp_err;

    modport master (
        output cmd_valid, cmd_mode, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );
endinterface

// File: rtl/spi_cmd_queue.sv
// spi_cmd_queue: FIFO-buffered command front-end for spi_master with a watchdog on spi_done.
// Define SPI_CMD_GAP_EN to insert GAP_CYCLES idle cycles after every response handshake.
module spi_cmd_queue #(
    parameter int FIFO_DEPTH  = 8,
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 4096,
    parameter int GAP_CYCLES  = 50
) (
    input  logic             sys_clk,
    input  logic             sys_rst,
    spi_cmd_queue_if.slave   cmd_if,
    output logic             busy,
    output logic [FIFO_AW:0] fifo_level,
    output logic             spi_en,
    output logic [1:0]       spi_mode,
    output logic [15:0]      spi_sdata,
    input  logic             spi_done,
    input  logic [15:0]      spi_rdata
);

    localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

    if ((1 << FIFO_AW) != FIFO_DEPTH || FIFO_DEPTH < 2 || FIFO_DEPTH > 64 ||
        TIMEOUT_CYC < 2 || GAP_CYCLES < 1) begin : g_bad_params
        $error("spi_cmd_queue: invalid parameter combination");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_LAUNCH,
        S_WAIT,
        S_RESP
`ifdef SPI_CMD_GAP_EN
        , S_GAP
`endif
    } state_t;

    state_t             state;
    logic [17:0]        mem [FIFO_DEPTH];
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [TO_W-1:0]    to_cnt;
    logic               rsp_valid_q;
    logic [15:0]        rsp_data_q;
    logic               rsp_err_q;
    logic               push;
    logic               pop;

`ifdef SPI_CMD_GAP_EN
    localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    logic [GAP_W-1:0]   gap_cnt;
`endif

    // cmd_ready is forced low while reset is held so every output reads 0 in reset
    assign cmd_if.cmd_ready = !sys_rst && (count < (FIFO_AW+1)'(FIFO_DEPTH));
    assign push             = cmd_if.cmd_valid && cmd_if.cmd_ready;
    assign pop              = (state == S_IDLE) && (count != '0);
    assign fifo_level       = count;
    assign busy             = (state != S_IDLE) || (count != '0);
    assign cmd_if.rsp_valid = rsp_valid_q;
    assign cmd_if.rsp_data  = rsp_data_q;
    assign cmd_if.rsp_err   = rsp_err_q;

    always_ff @(posedge sys_clk) begin
        if (push) begin
            mem[wr_ptr] <= {cmd_if.cmd_mode, cmd_if.cmd_data};
        end
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Timeout fires when the counter would step onto TIMEOUT_CYC-1; a coincident spi_done wins
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state       <= S_IDLE;
            spi_en      <= 1'b0;
            spi_mode    <= '0;
            spi_sdata   <= '0;
            to_cnt      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
`ifdef SPI_CMD_GAP_EN
            gap_cnt     <= '0;
`endif
        end else begin
            spi_en <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (pop) begin
                        {spi_mode, spi_sdata} <= mem[rd_ptr];
                        spi_en                <= 1'b1;
                        state                 <= S_LAUNCH;
                    end
                end
                S_LAUNCH: begin
                    to_cnt <= '0;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (spi_done) begin
                        rsp_data_q  <= spi_rdata;
                        rsp_err_q   <= 1'b0;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else if (to_cnt == TO_W'(TIMEOUT_CYC - 2)) begin
                        rsp_data_q  <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state       <= S_RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (cmd_if.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
`ifdef SPI_CMD_GAP_EN
                        gap_cnt     <= '0;
                        state       <= S_GAP;
`else
                        state       <= S_IDLE;
`endif
                    end
                end
`ifdef SPI_CMD_GAP_EN
                S_GAP: begin
                    if (gap_cnt == GAP_W'(GAP_CYCLES - 1)) begin
                        state <= S_IDLE;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_cmd_queue.sv
// Directed self-checking bench for spi_cmd_queue: latency, fill/order, backpressure, reset, timeout.
// A second instance with TIMEOUT_CYC=16 exercises the watchdog path.
module tb_spi_cmd_queue;

`ifdef SPI_CMD_GAP_EN
    localparam int EXP_GAP = 50 + 2;
`else
    localparam int EXP_GAP = 2;
`endif

    logic        sys_clk = 1'b0;
    logic        sys_rst = 1'b1;
    logic        busy;
    logic [3:0]  fifo_level;
    logic        spi_en;
    logic [1:0]  spi_mode;
    logic [15:0] spi_sdata;
    logic        spi_done = 1'b0;
    logic [15:0] spi_rdata = '0;

    logic        to_busy;
    logic [3:0]  to_level;
    logic        to_en;
    logic [1:0]  to_mode;
    logic [15:0] to_sdata;
    logic        to_done = 1'b0;
    logic [15:0] to_rdata = '0;

    spi_cmd_queue_if bus();
    spi_cmd_queue_if to_bus();

    spi_cmd_queue dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_if(bus),
        .busy(busy), .fifo_level(fifo_level), .spi_en(spi_en), .spi_mode(spi_mode),
        .spi_sdata(spi_sdata), .spi_done(spi_done), .spi_rdata(spi_rdata)
    );

    spi_cmd_queue #(.TIMEOUT_CYC(16)) dut_to (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .cmd_if(to_bus),
        .busy(to_busy), .fifo_level(to_level), .spi_en(to_en), .spi_mode(to_mode),
        .spi_sdata(to_sdata), .spi_done(to_done), .spi_rdata(to_rdata)
    );

    always #10 sys_clk = ~sys_clk;

    int cyc = 0;
    always @(posedge sys_clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Responder model for the main instance: spi_done resp_delay cycles after spi_en
    logic        resp_en = 1'b0;
    int          resp_delay = 1;
    logic        use_fixed = 1'b0;
    logic [15:0] fixed_rdata = '0;
    logic        resp_pend = 1'b0;
    int          resp_cnt = 0;
    int          en_count = 0;

    always @(negedge sys_clk) begin
        spi_done = 1'b0;
        if (spi_en) begin
            en_count++;
            resp_pend = 1'b1;
            resp_cnt  = resp_delay;
        end else if (resp_pend && resp_en) begin
            if (resp_cnt <= 1) begin
                spi_done  = 1'b1;
                spi_rdata = use_fixed ? fixed_rdata : spi_sdata;
                resp_pend = 1'b0;
            end else begin
                resp_cnt--;
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [1:0] mode, input logic [15:0] data);
        int n;
        n = 0;
        @(negedge sys_clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_mode  = mode;
        bus.cmd_data  = data;
        while (!bus.cmd_ready && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        checkOutput("push_ready", 32'(bus.cmd_ready), 1);
        @(posedge sys_clk);
        #1;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic waitEn(input string tag, output int en_cyc);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (!spi_en && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        en_cyc = cyc;
        checkOutput(tag, 32'(spi_en), 1);
    endtask

    task automatic takeResponse(input string tag, input logic [15:0] exp_data, input logic exp_err,
                                output int hs_cyc);
        int n;
        n = 0;
        @(negedge sys_clk);
        while (!bus.rsp_valid && n < 300) begin
            @(negedge sys_clk);
            n++;
        end
        hs_cyc = cyc;
        checkOutput({tag, "_valid"}, 32'(bus.rsp_valid), 1);
        checkOutput({tag, "_data"}, 32'(bus.rsp_data), 32'(exp_data));
        checkOutput({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
        bus.rsp_ready = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not complete");
        $fatal(1, "[TB] stopping");
    end

    int acc_cyc, en_cyc, rsp_cyc, hs_cyc, en_base, viol, bad, n;
    logic seen;
    logic [15:0] held;

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_mode = '0; bus.cmd_data = '0; bus.rsp_ready = 1'b0;
        to_bus.cmd_valid = 1'b0; to_bus.cmd_mode = '0; to_bus.cmd_data = '0; to_bus.rsp_ready = 1'b0;

        // Reset state
        repeat (3) @(negedge sys_clk);
        checkOutput("rst_cmd_ready", 32'(bus.cmd_ready), 0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 0);
        checkOutput("rst_busy", 32'(busy), 0);
        checkOutput("rst_level", 32'(fifo_level), 0);
        checkOutput("rst_spi_en", 32'(spi_en), 0);
        checkOutput("rst_sdata", 32'(spi_sdata), 0);
        sys_rst = 1'b0;
        @(negedge sys_clk);
        checkOutput("post_rst_cmd_ready", 32'(bus.cmd_ready), 1);

        // Single command: spi_en 2 cycles after the accept cycle, response the cycle after spi_done
        use_fixed = 1'b1; fixed_rdata = 16'h1234; resp_delay = 40; resp_en = 1'b1;
        applyStimulus(2'b00, 16'hA55A);
        acc_cyc = cyc - 1;
        waitEn("single_en_seen", en_cyc);
        checkOutput("single_en_latency", 32'(en_cyc - acc_cyc), 2);
        checkOutput("single_sdata", 32'(spi_sdata), 32'hA55A);
        checkOutput("single_mode", 32'(spi_mode), 0);
        @(negedge sys_clk);
        checkOutput("single_en_one_cycle", 32'(spi_en), 0);
        takeResponse("single_rsp", 16'h1234, 1'b0, rsp_cyc);
        checkOutput("single_rsp_latency", 32'(rsp_cyc - en_cyc), 41);
        use_fixed = 1'b0;

        // Fill and order: spi_done withheld, 9 accepted, FIFO holds 8
        resp_en = 1'b0; resp_delay = 2;
        for (int i = 1; i <= 9; i++) applyStimulus(2'(i % 4), 16'(i));
        @(negedge sys_clk);
        checkOutput("fill_level", 32'(fifo_level), 8);
        checkOutput("fill_cmd_ready", 32'(bus.cmd_ready), 0);
        bus.cmd_valid = 1'b1; bus.cmd_data = 16'h000A;
        repeat (3) @(negedge sys_clk);
        bus.cmd_valid = 1'b0;
        checkOutput("full_no_accept_level", 32'(fifo_level), 8);
        resp_en = 1'b1;
        for (int i = 1; i <= 9; i++) takeResponse("fill_rsp", 16'(i), 1'b0, hs_cyc);
        @(negedge sys_clk);
        checkOutput("fill_drained_level", 32'(fifo_level), 0);
        checkOutput("fill_drained_busy", 32'(busy), 0);

        // Backpressure: rsp_ready low for 100 cycles with three commands queued
        resp_delay = 3;
        en_base = en_count;
        applyStimulus(2'b11, 16'h1111);
        applyStimulus(2'b01, 16'h2222);
        applyStimulus(2'b10, 16'h3333);
        viol = 0; seen = 1'b0; held = '0;
        for (int i = 0; i < 100; i++) begin
            @(negedge sys_clk);
            if (bus.rsp_valid && !seen) begin
                seen = 1'b1;
                held = bus.rsp_data;
            end else if (seen && (!bus.rsp_valid || bus.rsp_data !== held)) begin
                viol++;
            end
        end
        checkOutput("bp_one_launch", 32'(en_count - en_base), 1);
        checkOutput("bp_valid_held", 32'(bus.rsp_valid), 1);
        checkOutput("bp_stable", 32'(viol), 0);
        checkOutput("bp_level", 32'(fifo_level), 2);
        takeResponse("bp_rsp1", 16'h1111, 1'b0, hs_cyc);
        waitEn("bp_en2_seen", en_cyc);
        checkOutput("bp_next_launch_gap", 32'(en_cyc - hs_cyc), 32'(EXP_GAP));
        checkOutput("bp_en2_sdata", 32'(spi_sdata), 32'h2222);
        checkOutput("bp_en2_mode", 32'(spi_mode), 1);
        takeResponse("bp_rsp2", 16'h2222, 1'b0, hs_cyc);
        takeResponse("bp_rsp3", 16'h3333, 1'b0, hs_cyc);

        // Reset in WAIT; a late spi_done must not produce a response
        resp_en = 1'b0;
        applyStimulus(2'b00, 16'h4444);
        applyStimulus(2'b00, 16'h5555);
        waitEn("rst_mid_en_seen", en_cyc);
        repeat (5) @(negedge sys_clk);
        sys_rst = 1'b1;
        @(negedge sys_clk);
        checkOutput("rst_mid_cmd_ready", 32'(bus.cmd_ready), 0);
        checkOutput("rst_mid_level", 32'(fifo_level), 0);
        checkOutput("rst_mid_sdata", 32'(spi_sdata), 0);
        sys_rst = 1'b0;
        resp_en = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge sys_clk);
            if (bus.rsp_valid || spi_en) bad++;
        end
        checkOutput("rst_mid_no_activity", 32'(bad), 0);
        checkOutput("rst_mid_busy", 32'(busy), 0);
        checkOutput("rst_mid_level_after", 32'(fifo_level), 0);
        checkOutput("rst_mid_rsp_data", 32'(bus.rsp_data), 0);
        checkOutput("rst_mid_rsp_err", 32'(bus.rsp_err), 0);
        checkOutput("rst_mid_mode", 32'(spi_mode), 0);

        // Timeout instance: no spi_done, then a done landing on the last WAIT cycle
        @(negedge sys_clk);
        to_bus.cmd_valid = 1'b1; to_bus.cmd_mode = 2'b01; to_bus.cmd_data = 16'h0BAD;
        checkOutput("to_cmd_ready", 32'(to_bus.cmd_ready), 1);
        @(posedge sys_clk); #1;
        to_bus.cmd_valid = 1'b0;
        n = 0;
        @(negedge sys_clk);
        while (!to_en && n < 100) begin @(negedge sys_clk); n++; end
        checkOutput("to_en_seen", 32'(to_en), 1);
        en_cyc = cyc;
        n = 0;
        @(negedge sys_clk);
        while (!to_bus.rsp_valid && n < 100) begin @(negedge sys_clk); n++; end
        checkOutput("to_rsp_latency", 32'(cyc - en_cyc), 16);
        checkOutput("to_rsp_err", 32'(to_bus.rsp_err), 1);
        checkOutput("to_rsp_data", 32'(to_bus.rsp_data), 0);
        to_bus.rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        to_bus.rsp_ready = 1'b0;

        @(negedge sys_clk);
        to_bus.cmd_valid = 1'b1; to_bus.cmd_data = 16'h0C0D;
        @(posedge sys_clk); #1;
        to_bus.cmd_valid = 1'b0;
        n = 0;
        @(negedge sys_clk);
        while (!to_en && n < 100) begin @(negedge sys_clk); n++; end
        checkOutput("to2_en_seen", 32'(to_en), 1);
        checkOutput("to2_sdata", 32'(to_sdata), 32'h0C0D);
        repeat (15) @(negedge sys_clk);
        to_done = 1'b1; to_rdata = 16'h7777;
        @(negedge sys_clk);
        to_done = 1'b0;
        checkOutput("to2_done_wins_valid", 32'(to_bus.rsp_valid), 1);
        checkOutput("to2_done_wins_err", 32'(to_bus.rsp_err), 0);
        checkOutput("to2_done_wins_data", 32'(to_bus.rsp_data), 32'h7777);
        to_bus.rsp_ready = 1'b1;
        @(posedge sys_clk); #1;
        to_bus.rsp_ready = 1'b0;
        repeat (2) @(negedge sys_clk);
        checkOutput("to_idle_busy", 32'(to_busy), 0);
        checkOutput("to_idle_level", 32'(to_level), 0);
        checkOutput("to_mode_held", 32'(to_mode), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
